debug_tx_serializer: RTL and testbench
======================================

DEBUG_TX_SERIALIZER -- requirements
Module: debug_tx_serializer

Interface
REQ-001 SHALL have parameter: ADDR_W, 6, log2 of FIFO depth in 32-bit words (depth 64).
REQ-002 SHALL have port: i_clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port: i_reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: i_wr_en  input  1  push request from the debug unit's FIFO-write strobe.
REQ-005 SHALL have port: i_wr_data  input  32  word to push.
REQ-006 SHALL have port: o_full  output  1  FIFO holds 2**ADDR_W words.
REQ-007 SHALL have port: o_empty  output  1  FIFO holds 0 words.
REQ-008 SHALL have port: o_count  output  ADDR_W+1  words currently stored.
REQ-009 SHALL have port: o_overflow  output  1  sticky flag, a push was dropped.
REQ-010 SHALL have port: o_tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port: o_tx_byte  output  8  byte for the UART transmitter, valid while o_tx_start is high.
REQ-012 SHALL have port: i_tx_done  input  1  one-cycle pulse from the UART transmitter, byte fully sent.

Function
REQ-013 SHALL store words in a circular FIFO of 2**ADDR_W entries; read/write pointers ADDR_W bits, wrapping from 2**ADDR_W-1 to 0.
REQ-014 SHALL accept a push when i_wr_en=1 and (o_full=0 or a pop occurs in the same cycle); full plus simultaneous pop leaves o_count unchanged.
REQ-015 SHALL drop a push when i_wr_en=1, o_full=1, no pop; set o_overflow=1 until reset; FIFO contents unchanged.
REQ-016 SHALL derive o_full, o_empty, o_count from registered state, updated on the edge of each push/pop.
REQ-017 SHALL implement FSM states IDLE, LOAD, SEND, WAIT, CHK.
REQ-018 IDLE: SHALL go to LOAD when o_count!=0.
REQ-019 LOAD: SHALL pop head word into 32-bit shift register, clear byte index to 0, go to SEND.
REQ-020 SEND: SHALL hold o_tx_start=1 for exactly this one cycle with o_tx_byte=shift[31:24], then go to WAIT.
REQ-021 WAIT: on i_tx_done=1, if byte index<3, SHALL shift left by 8, increment index, go to SEND; if index=3, go to CHK when REQ-029 applies, else IDLE.
REQ-022 SHALL transmit bytes MSB first (word 0x656E6464 sends 0x65,0x6E,0x64,0x64).
REQ-023 SHALL ignore i_tx_done in every state except WAIT/CHK-wait.
REQ-024 first o_tx_start for a word pushed into an empty idle block SHALL occur in the cycle following the 2nd rising edge after the accepting edge.
REQ-025 SHALL keep o_tx_start=0 in all states other than SEND and CHK-send; o_tx_byte holds last driven value otherwise.
REQ-026 SHALL allow pushes in every FSM state; pops occur only in LOAD.

Reset
REQ-027 On i_reset=1 at a rising edge SHALL set: pointers 0, o_count 0, o_empty 1, o_full 0, o_overflow 0, o_tx_start 0, o_tx_byte 0x00, state IDLE, byte index 0, checksum 0.
REQ-028 Reset mid-transmission SHALL discard the in-flight word and all stored words; a pending i_tx_done after reset is ignored.

Configuration
REQ-029 With macro DEBUG_TX_CHECKSUM_EN defined, SHALL keep a running 8-bit XOR of every byte sent; after the last byte of word 0x656E6464 ("endd") is done, SHALL enter CHK: pulse o_tx_start one cycle with o_tx_byte=XOR, wait i_tx_done, clear XOR, go IDLE.
REQ-030 Without DEBUG_TX_CHECKSUM_EN, SHALL contain no CHK state nor XOR register; "endd" is sent as ordinary 4 bytes.

Verification
REQ-031 Push 0x11223344 into empty block, i_tx_done 5 cycles after each start -> starts carry 0x11,0x22,0x33,0x44; first start 2 edges after push; o_empty=1 after LOAD.
REQ-032 Push 65 words with i_tx_done held 0 -> first word popped, 64 stored, o_full=1; 66th push dropped, o_overflow=1, stored data intact on drain.
REQ-033 Fill to 64, then push in the LOAD cycle -> push accepted, o_count stays 64, no overflow.
REQ-034 Assert i_reset during WAIT after 2nd byte -> all outputs at reset values next cycle, later i_tx_done produces no o_tx_start.
REQ-035 With DEBUG_TX_CHECKSUM_EN: push 0x00000001 then 0x656E6464 -> 9 starts, last byte 0x01^0x65^0x6E^0x64^0x64=0x0A; without macro -> 8 starts.
REQ-036 Pulse i_tx_done in IDLE and SEND -> no state change, no extra o_tx_start.

Source files
------------

// File: rtl/debug_tx_serializer.sv
// ============================================================================
// Module   : debug_tx_serializer
// Function : 32-bit word FIFO that feeds a byte-wide UART transmitter, MSB first.
// Options  : DEBUG_TX_CHECKSUM_EN appends an XOR checksum byte after "endd".
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_tx_serializer #(
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [31:0]       i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_done
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam logic [31:0]     END_WORD   = 32'h656E_6464;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3
`ifdef DEBUG_TX_CHECKSUM_EN
        ,
        CHK      = 3'd4,
        CHK_WAIT = 3'd5
`endif
    } state_t;

    logic [31:0]       mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0]        chk_xor_q, chk_xor_d;
    logic              is_end_q, is_end_d;
`endif

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (count_q == FULL_COUNT);
    assign w_pop  = (state_q == LOAD);
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign w_push = i_wr_en && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
`ifdef DEBUG_TX_CHECKSUM_EN
        chk_xor_d  = chk_xor_q;
        is_end_d   = is_end_q;
`endif

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
        if (i_wr_en && !w_push) begin
            overflow_d = 1'b1;
        end

        // shift_q[31:24] doubles as the output byte, so it always holds the last byte driven.
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d    = mem_q[rd_ptr_q];
                byte_idx_d = 2'd0;
`ifdef DEBUG_TX_CHECKSUM_EN
                is_end_d   = (mem_q[rd_ptr_q] == END_WORD);
`endif
                state_d    = SEND;
            end
            SEND: begin
`ifdef DEBUG_TX_CHECKSUM_EN
                chk_xor_d = chk_xor_q ^ shift_q[31:24];
`endif
                state_d   = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (byte_idx_q != 2'd3) begin
                        shift_d    = {shift_q[23:0], 8'h00};
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = SEND;
                    end else begin
`ifdef DEBUG_TX_CHECKSUM_EN
                        if (is_end_q) begin
                            shift_d = {chk_xor_q, 24'h000000};
                            state_d = CHK;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            CHK: begin
                state_d = CHK_WAIT;
            end
            CHK_WAIT: begin
                if (i_tx_done) begin
                    chk_xor_d = 8'h00;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            shift_q    <= 32'h0;
            byte_idx_q <= 2'd0;
`ifdef DEBUG_TX_CHECKSUM_EN
            chk_xor_q  <= 8'h00;
            is_end_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
`ifdef DEBUG_TX_CHECKSUM_EN
            chk_xor_q  <= chk_xor_d;
            is_end_q   <= is_end_d;
`endif
        end
    end

    assign o_full     = w_full;
    assign o_empty    = (count_q == '0);
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_tx_byte  = shift_q[31:24];
`ifdef DEBUG_TX_CHECKSUM_EN
    assign o_tx_start = (state_q == SEND) || (state_q == CHK);
`else
    assign o_tx_start = (state_q == SEND);
`endif

endmodule

`default_nettype wire

// File: tb/tb_debug_tx_serializer.sv
// ============================================================================
// Module   : tb_debug_tx_serializer
// Function : Directed self-checking bench for debug_tx_serializer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_debug_tx_serializer;

    localparam int ADDR_W = 6;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_wr_en;
    logic [31:0]     i_wr_data;
    logic            o_full;
    logic            o_empty;
    logic [ADDR_W:0] o_count;
    logic            o_overflow;
    logic            o_tx_start;
    logic [7:0]      o_tx_byte;
    logic            i_tx_done;

    int n_checks  = 0;
    int n_pass    = 0;
    int start_cnt = 0;

    debug_tx_serializer #(.ADDR_W(ADDR_W)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_tx_start (o_tx_start),
        .o_tx_byte  (o_tx_byte),
        .i_tx_done  (i_tx_done)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_tx_start) start_cnt++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset   = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_data = 32'h0;
        i_tx_done = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    // Waits for a start pulse, captures its byte, then answers with i_tx_done 5 cycles later.
    task automatic get_byte(input int budget, output logic [7:0] b, output bit ok);
        int n = 0;
        ok = 1'b0;
        b  = 8'h00;
        while (!o_tx_start && n < budget) begin
            tick();
            n++;
        end
        if (o_tx_start) begin
            ok = 1'b1;
            b  = o_tx_byte;
            repeat (4) tick();
            pulse_done();
        end
    endtask

    task automatic fill_65();
        i_wr_en = 1'b1;
        for (int k = 0; k < 65; k++) begin
            i_wr_data = 32'(k);
            tick();
        end
        i_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        i_wr_en   = 1'b1;
        i_wr_data = 32'hFFFF_FFFF;
        i_reset   = 1'b1;
        tick();
        i_wr_en = 1'b0;
        tick();
        i_reset = 1'b0;
        n_checks++; if (o_count !== 7'd0) $display("FAIL reset_count: got %0d want 0", o_count); else n_pass++;
        n_checks++; if (o_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", o_empty); else n_pass++;
        n_checks++; if (o_full !== 1'b0) $display("FAIL reset_full: got %b want 0", o_full); else n_pass++;
        n_checks++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", o_overflow); else n_pass++;
        n_checks++; if (o_tx_start !== 1'b0) $display("FAIL reset_start: got %b want 0", o_tx_start); else n_pass++;
        n_checks++; if (o_tx_byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", o_tx_byte); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        push(32'h1122_3344);
        n_checks++; if (o_count !== 7'd1) $display("FAIL basic_count_after_push: got %0d want 1", o_count); else n_pass++;
        n_checks++; if (o_empty !== 1'b0) $display("FAIL basic_empty_after_push: got %b want 0", o_empty); else n_pass++;
        n_checks++; if (o_tx_start !== 1'b0) $display("FAIL basic_start_edge0: got %b want 0", o_tx_start); else n_pass++;
        tick();
        n_checks++; if (o_tx_start !== 1'b0) $display("FAIL basic_start_edge1: got %b want 0", o_tx_start); else n_pass++;
        tick();
        n_checks++; if (o_tx_start !== 1'b1) $display("FAIL basic_start_edge2: got %b want 1", o_tx_start); else n_pass++;
        n_checks++; if (o_tx_byte !== exp_b[0]) $display("FAIL basic_byte0: got %h want %h", o_tx_byte, exp_b[0]); else n_pass++;
        n_checks++; if (o_empty !== 1'b1) $display("FAIL basic_empty_after_load: got %b want 1", o_empty); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            repeat (4) tick();
            pulse_done();
            n_checks++;
            if (o_tx_start !== 1'b1 || o_tx_byte !== exp_b[i])
                $display("FAIL basic_byte%0d: got start=%b byte=%h want start=1 byte=%h", i, o_tx_start, o_tx_byte, exp_b[i]);
            else n_pass++;
        end
        repeat (4) tick();
        pulse_done();
        tick();
        n_checks++; if (o_tx_start !== 1'b0) $display("FAIL basic_idle_start: got %b want 0", o_tx_start); else n_pass++;
        n_checks++; if (o_tx_byte !== 8'h44) $display("FAIL basic_byte_hold: got %h want 44", o_tx_byte); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        logic [7:0]  b;
        bit          ok;
        bit          all_ok;
        do_reset();
        fill_65();
        n_checks++; if (o_count !== 7'd64) $display("FAIL ovf_count_full: got %0d want 64", o_count); else n_pass++;
        n_checks++; if (o_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", o_full); else n_pass++;
        n_checks++; if (o_overflow !== 1'b0) $display("FAIL ovf_flag_early: got %b want 0", o_overflow); else n_pass++;
        push(32'hDEAD_BEEF);
        n_checks++; if (o_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", o_overflow); else n_pass++;
        n_checks++; if (o_count !== 7'd64) $display("FAIL ovf_count_after_drop: got %0d want 64", o_count); else n_pass++;
        // Word 0 already had its first byte (0x00) sent while the FIFO was filling.
        pulse_done();
        w = 32'h0;
        all_ok = 1'b1;
        for (int j = 0; j < 3; j++) begin
            get_byte(50, b, ok);
            all_ok &= ok;
            w = {w[23:0], b};
        end
        n_checks++; if (!all_ok || w !== 32'h0) $display("FAIL ovf_word0: got %h ok=%b want 00000000", w, all_ok); else n_pass++;
        for (int k = 1; k < 65; k++) begin
            w = 32'h0;
            all_ok = 1'b1;
            for (int j = 0; j < 4; j++) begin
                get_byte(50, b, ok);
                all_ok &= ok;
                w = {w[23:0], b};
            end
            n_checks++;
            if (!all_ok || w !== 32'(k)) $display("FAIL ovf_word%0d: got %h ok=%b want %h", k, w, all_ok, 32'(k));
            else n_pass++;
        end
        get_byte(30, b, ok);
        n_checks++; if (ok !== 1'b0) $display("FAIL ovf_dropped_sent: got byte %h want no start", b); else n_pass++;
        n_checks++; if (o_empty !== 1'b1) $display("FAIL ovf_drained_empty: got %b want 1", o_empty); else n_pass++;
        n_checks++; if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", o_overflow); else n_pass++;
    endtask

    task automatic test_full_pop_push();
        do_reset();
        fill_65();
        for (int i = 0; i < 3; i++) begin
            pulse_done();
            tick();
        end
        pulse_done();
        n_checks++; if (o_count !== 7'd64 || o_tx_start !== 1'b0)
            $display("FAIL fpp_before_load: got count=%0d start=%b want count=64 start=0", o_count, o_tx_start);
        else n_pass++;
        tick();
        i_wr_en   = 1'b1;
        i_wr_data = 32'hCAFE_F00D;
        tick();
        i_wr_en = 1'b0;
        n_checks++; if (o_count !== 7'd64) $display("FAIL fpp_count: got %0d want 64", o_count); else n_pass++;
        n_checks++; if (o_full !== 1'b1) $display("FAIL fpp_full: got %b want 1", o_full); else n_pass++;
        n_checks++; if (o_overflow !== 1'b0) $display("FAIL fpp_overflow: got %b want 0", o_overflow); else n_pass++;
        n_checks++; if (o_tx_start !== 1'b1 || o_tx_byte !== 8'h00)
            $display("FAIL fpp_next_start: got start=%b byte=%h want start=1 byte=00", o_tx_start, o_tx_byte);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        bit         ok;
        int         base;
        do_reset();
        push(32'h1122_3344);
        push(32'h5566_7788);
        get_byte(20, b, ok);
        n_checks++; if (!ok || b !== 8'h11) $display("FAIL rmid_byte0: got %h ok=%b want 11", b, ok); else n_pass++;
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_checks++; if (o_tx_start !== 1'b0 || o_tx_byte !== 8'h00)
            $display("FAIL rmid_tx_outputs: got start=%b byte=%h want 0/00", o_tx_start, o_tx_byte);
        else n_pass++;
        n_checks++; if (o_count !== 7'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_overflow !== 1'b0)
            $display("FAIL rmid_fifo: got count=%0d empty=%b full=%b ovf=%b want 0/1/0/0", o_count, o_empty, o_full, o_overflow);
        else n_pass++;
        base = start_cnt;
        pulse_done();
        repeat (10) tick();
        n_checks++; if (start_cnt !== base) $display("FAIL rmid_no_start: got %0d starts want 0", start_cnt - base); else n_pass++;
    endtask

    task automatic test_done_ignored();
        logic [7:0] b;
        bit         ok;
        int         base;
        do_reset();
        base = start_cnt;
        pulse_done();
        tick();
        n_checks++; if (start_cnt !== base || o_count !== 7'd0)
            $display("FAIL ign_idle: got starts=%0d count=%0d want 0/0", start_cnt - base, o_count);
        else n_pass++;
        push(32'hA1B2_C3D4);
        tick();
        tick();
        n_checks++; if (o_tx_start !== 1'b1 || o_tx_byte !== 8'hA1)
            $display("FAIL ign_first: got start=%b byte=%h want 1/a1", o_tx_start, o_tx_byte);
        else n_pass++;
        pulse_done();
        n_checks++; if (o_tx_start !== 1'b0) $display("FAIL ign_send_start: got %b want 0", o_tx_start); else n_pass++;
        repeat (3) tick();
        pulse_done();
        n_checks++; if (o_tx_start !== 1'b1 || o_tx_byte !== 8'hB2)
            $display("FAIL ign_second: got start=%b byte=%h want 1/b2", o_tx_start, o_tx_byte);
        else n_pass++;
        for (int i = 0; i < 3; i++) get_byte(20, b, ok);
        n_checks++; if (!ok || b !== 8'hD4) $display("FAIL ign_last: got %h ok=%b want d4", b, ok); else n_pass++;
    endtask

    task automatic test_checksum();
        logic [7:0] b;
        logic [7:0] last;
        bit         ok;
        int         n;
        int         exp_n;
        logic [7:0] exp_last;
`ifdef DEBUG_TX_CHECKSUM_EN
        exp_n    = 9;
        exp_last = 8'h0A;
`else
        exp_n    = 8;
        exp_last = 8'h64;
`endif
        do_reset();
        push(32'h0000_0001);
        push(32'h656E_6464);
        n    = 0;
        last = 8'h00;
        for (int i = 0; i < 12; i++) begin
            get_byte(40, b, ok);
            if (!ok) break;
            n++;
            last = b;
        end
        n_checks++; if (n !== exp_n) $display("FAIL chk_start_count: got %0d want %0d", n, exp_n); else n_pass++;
        n_checks++; if (last !== exp_last) $display("FAIL chk_last_byte: got %h want %h", last, exp_last); else n_pass++;
    endtask

    initial begin
        i_reset   = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_data = 32'h0;
        i_tx_done = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        test_done_ignored();
        test_checksum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
